// File: rtl/l2_write_buffer_pkg.sv
// rtl/l2_write_buffer_pkg.sv - shared line/address types, entry record and FSM states for the L2 write buffer
package l2_write_buffer_pkg;

    localparam int ADDR_W = 12;
    localparam int LINE_W = 128;
    localparam int SEL_W  = 16;

    localparam logic [SEL_W-1:0] SEL_FULL_LINE = '1;

    typedef logic [LINE_W-1:0] lc3b_line;
    typedef logic [ADDR_W-1:0] lc3b_line_addr;

    typedef struct packed {
        logic          valid;
        lc3b_line_addr addr;
        lc3b_line      data;
    } wbuf_entry_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WR_MEM = 2'd1,
        RD_MEM = 2'd2,
        RESP   = 2'd3
    } wbuf_state_t;

endpackage

// File: rtl/l2_write_buffer_cam_fifo.sv
// rtl/l2_write_buffer_cam_fifo.sv - circular line FIFO with parallel address match (newest hit wins)
module wbuf_cam_fifo
    import l2_write_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_valid,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic [LINE_W-1:0] push_data,
    input  logic              upd_valid,
    input  logic [PTR_W-1:0]  upd_idx,
    input  logic [LINE_W-1:0] upd_data,
    input  logic              pop_valid,
    input  logic [ADDR_W-1:0] match_addr,
    input  logic [DEPTH-1:0]  match_mask,
    output logic              hit,
    output logic [PTR_W-1:0]  hit_idx,
    output logic [LINE_W-1:0] hit_data,
    output logic [PTR_W-1:0]  head_idx,
    output logic [ADDR_W-1:0] head_addr,
    output logic [LINE_W-1:0] head_data,
    output logic              full,
    output logic              empty
);

    wbuf_entry_t       entries_q [DEPTH];
    wbuf_entry_t       entries_d [DEPTH];
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic [PTR_W-1:0]  age;
    logic [PTR_W-1:0]  best_age;

    // Age relative to head orders entries oldest-first, so the largest age is the newest match.
    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        best_age = '0;
        age      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            age = PTR_W'(i) - head_q;
            if (entries_q[i].valid && !match_mask[i] &&
                (entries_q[i].addr == match_addr) && (!hit || (age > best_age))) begin
                hit      = 1'b1;
                hit_idx  = PTR_W'(i);
                best_age = age;
            end
        end
    end

    assign hit_data  = entries_q[hit_idx].data;
    assign head_idx  = head_q;
    assign head_addr = entries_q[head_q].addr;
    assign head_data = entries_q[head_q].data;
    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);

    // Pop is applied before push so a full buffer can refill the slot it frees in the same cycle.
    always_comb begin
        entries_d = entries_q;
        head_d    = head_q;
        tail_d    = tail_q;
        if (pop_valid) begin
            entries_d[head_q].valid = 1'b0;
            head_d                  = head_q + 1'b1;
        end
        if (upd_valid) begin
            entries_d[upd_idx].data = upd_data;
        end
        if (push_valid) begin
            entries_d[tail_q].valid = 1'b1;
            entries_d[tail_q].addr  = push_addr;
            entries_d[tail_q].data  = push_data;
            tail_d                  = tail_q + 1'b1;
        end
        count_d = count_q + CNT_W'(push_valid) - CNT_W'(pop_valid);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            entries_q <= entries_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
        end
    end

endmodule

// File: rtl/l2_write_buffer.sv
// rtl/l2_write_buffer.sv - posted-write buffer between L2 and pmem wishbone ports
// Define L2WB_RAW_FWD_EN to serve read hits from the buffer instead of draining first.
module l2_write_buffer
    import l2_write_buffer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              wb_l2_cyc,
    input  logic              wb_l2_stb,
    input  logic              wb_l2_we,
    input  logic [ADDR_W-1:0] wb_l2_adr,
    input  logic [SEL_W-1:0]  wb_l2_sel,
    input  logic [LINE_W-1:0] wb_l2_dat_m,
    output logic              wb_l2_ack,
    output logic              wb_l2_rty,
    output logic [LINE_W-1:0] wb_l2_dat_s,
    output logic              wb_pmem_cyc,
    output logic              wb_pmem_stb,
    output logic              wb_pmem_we,
    output logic [ADDR_W-1:0] wb_pmem_adr,
    output logic [SEL_W-1:0]  wb_pmem_sel,
    output logic [LINE_W-1:0] wb_pmem_dat_m,
    input  logic              wb_pmem_ack,
    input  logic              wb_pmem_rty,
    input  logic [LINE_W-1:0] wb_pmem_dat_s,
    output logic              full,
    output logic              empty
);

    localparam int PTR_W = $clog2(DEPTH);

    wbuf_state_t       state_q, state_d;
    logic              l2_ack_q, l2_ack_d;
    logic [LINE_W-1:0] l2_dat_s_q, l2_dat_s_d;
    logic              pmem_cyc_q, pmem_cyc_d;
    logic              pmem_stb_q, pmem_stb_d;
    logic              pmem_we_q, pmem_we_d;
    logic [ADDR_W-1:0] pmem_adr_q, pmem_adr_d;
    logic [SEL_W-1:0]  pmem_sel_q, pmem_sel_d;
    logic [LINE_W-1:0] pmem_dat_q, pmem_dat_d;

    logic              rd_req, wr_req, wr_accept;
    logic              pmem_done, pop;
    logic              start_drain, start_read;
    logic              hit;
    logic [PTR_W-1:0]  hit_idx, head_idx;
    logic [LINE_W-1:0] hit_data, head_data;
    logic [ADDR_W-1:0] head_addr;
    logic [DEPTH-1:0]  busy_mask, match_mask;
    logic              unused_pmem_rty;

    assign unused_pmem_rty = wb_pmem_rty;

    // The ACK cycle still shows the held request, so it must not be sampled twice.
    assign rd_req    = wb_l2_cyc && wb_l2_stb && !wb_l2_we && !l2_ack_q;
    assign wr_req    = wb_l2_cyc && wb_l2_stb &&  wb_l2_we && !l2_ack_q;
    assign pmem_done = pmem_cyc_q && wb_pmem_ack;
    assign pop       = (state_q == WR_MEM) && pmem_done;
    assign wr_accept = wr_req && (hit || !full || pop);

    // Head is off-limits for coalescing while draining or about to start draining; a write
    // request in IDLE with a non-empty buffer always starts a drain on this edge.
    always_comb begin
        busy_mask = '0;
        if ((state_q == WR_MEM) || ((state_q == IDLE) && !empty)) begin
            busy_mask[head_idx] = 1'b1;
        end
    end

    assign match_mask = wb_l2_we ? busy_mask : '0;

    wbuf_cam_fifo #(
        .DEPTH (DEPTH)
    ) u_cam_fifo (
        .clk        (CLK),
        .rst        (RST),
        .push_valid (wr_accept && !hit),
        .push_addr  (wb_l2_adr),
        .push_data  (wb_l2_dat_m),
        .upd_valid  (wr_accept && hit),
        .upd_idx    (hit_idx),
        .upd_data   (wb_l2_dat_m),
        .pop_valid  (pop),
        .match_addr (wb_l2_adr),
        .match_mask (match_mask),
        .hit        (hit),
        .hit_idx    (hit_idx),
        .hit_data   (hit_data),
        .head_idx   (head_idx),
        .head_addr  (head_addr),
        .head_data  (head_data),
        .full       (full),
        .empty      (empty)
    );

`ifndef L2WB_RAW_FWD_EN
    logic unused_hit_data;
    assign unused_hit_data = ^hit_data;
`endif

    always_comb begin
        state_d     = state_q;
        l2_ack_d    = wr_accept;
        l2_dat_s_d  = l2_dat_s_q;
        pmem_cyc_d  = pmem_cyc_q;
        pmem_stb_d  = pmem_stb_q;
        pmem_we_d   = pmem_we_q;
        pmem_adr_d  = pmem_adr_q;
        pmem_sel_d  = pmem_sel_q;
        pmem_dat_d  = pmem_dat_q;
        start_drain = 1'b0;
        start_read  = 1'b0;

        case (state_q)
            IDLE: begin
                // Full buffer drains ahead of reads so a stalled writer always progresses.
                if (!empty && (full || !rd_req)) begin
                    start_drain = 1'b1;
                end else if (rd_req) begin
`ifdef L2WB_RAW_FWD_EN
                    if (hit) begin
                        l2_ack_d   = 1'b1;
                        l2_dat_s_d = hit_data;
                        state_d    = RESP;
                    end else begin
                        start_read = 1'b1;
                    end
`else
                    if (hit) begin
                        start_drain = 1'b1;
                    end else begin
                        start_read = 1'b1;
                    end
`endif
                end
            end
            WR_MEM: begin
                if (pmem_done) begin
                    state_d = IDLE;
                end
            end
            RD_MEM: begin
                if (pmem_done) begin
                    state_d    = RESP;
                    l2_ack_d   = 1'b1;
                    l2_dat_s_d = wb_pmem_dat_s;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (pmem_done) begin
            pmem_cyc_d = 1'b0;
            pmem_stb_d = 1'b0;
            pmem_we_d  = 1'b0;
            pmem_adr_d = '0;
            pmem_sel_d = '0;
            pmem_dat_d = '0;
        end

        // pmem outputs are latched at launch so in-buffer updates cannot disturb a live cycle.
        if (start_drain) begin
            state_d    = WR_MEM;
            pmem_cyc_d = 1'b1;
            pmem_stb_d = 1'b1;
            pmem_we_d  = 1'b1;
            pmem_adr_d = head_addr;
            pmem_sel_d = SEL_FULL_LINE;
            pmem_dat_d = head_data;
        end else if (start_read) begin
            state_d    = RD_MEM;
            pmem_cyc_d = 1'b1;
            pmem_stb_d = 1'b1;
            pmem_we_d  = 1'b0;
            pmem_adr_d = wb_l2_adr;
            pmem_sel_d = wb_l2_sel;
            pmem_dat_d = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            l2_ack_q   <= 1'b0;
            l2_dat_s_q <= '0;
            pmem_cyc_q <= 1'b0;
            pmem_stb_q <= 1'b0;
            pmem_we_q  <= 1'b0;
            pmem_adr_q <= '0;
            pmem_sel_q <= '0;
            pmem_dat_q <= '0;
        end else begin
            state_q    <= state_d;
            l2_ack_q   <= l2_ack_d;
            l2_dat_s_q <= l2_dat_s_d;
            pmem_cyc_q <= pmem_cyc_d;
            pmem_stb_q <= pmem_stb_d;
            pmem_we_q  <= pmem_we_d;
            pmem_adr_q <= pmem_adr_d;
            pmem_sel_q <= pmem_sel_d;
            pmem_dat_q <= pmem_dat_d;
        end
    end

    assign wb_l2_ack     = l2_ack_q;
    assign wb_l2_rty     = 1'b0;
    assign wb_l2_dat_s   = l2_dat_s_q;
    assign wb_pmem_cyc   = pmem_cyc_q;
    assign wb_pmem_stb   = pmem_stb_q;
    assign wb_pmem_we    = pmem_we_q;
    assign wb_pmem_adr   = pmem_adr_q;
    assign wb_pmem_sel   = pmem_sel_q;
    assign wb_pmem_dat_m = pmem_dat_q;

endmodule

// File: tb/tb_l2_write_buffer.sv
// tb/tb_l2_write_buffer.sv - directed scoreboard bench for l2_write_buffer
module tb_l2_write_buffer;
    import l2_write_buffer_pkg::*;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] adr;
        logic [SEL_W-1:0]  sel;
        logic [LINE_W-1:0] dat;
    } pmem_txn_t;

    logic              CLK = 1'b0;
    logic              RST = 1'b1;
    logic              wb_l2_cyc = 1'b0, wb_l2_stb = 1'b0, wb_l2_we = 1'b0;
    logic [ADDR_W-1:0] wb_l2_adr = '0;
    logic [SEL_W-1:0]  wb_l2_sel = '0;
    logic [LINE_W-1:0] wb_l2_dat_m = '0;
    logic              wb_l2_ack, wb_l2_rty;
    logic [LINE_W-1:0] wb_l2_dat_s;
    logic              wb_pmem_cyc, wb_pmem_stb, wb_pmem_we;
    logic [ADDR_W-1:0] wb_pmem_adr;
    logic [SEL_W-1:0]  wb_pmem_sel;
    logic [LINE_W-1:0] wb_pmem_dat_m;
    logic              wb_pmem_ack = 1'b0;
    logic              wb_pmem_rty = 1'b0;
    logic [LINE_W-1:0] wb_pmem_dat_s = '0;
    logic              full, empty;

    pmem_txn_t         pmem_exp[$];
    logic [LINE_W-1:0] rd_exp[$];
    int                checks = 0;
    int                errors = 0;
    int                cyc_cnt = 0;
    int                last_pmem_ack = -1;
    logic              stall = 1'b0;

    l2_write_buffer #(.DEPTH(4)) dut (
        .CLK           (CLK),
        .RST           (RST),
        .wb_l2_cyc     (wb_l2_cyc),
        .wb_l2_stb     (wb_l2_stb),
        .wb_l2_we      (wb_l2_we),
        .wb_l2_adr     (wb_l2_adr),
        .wb_l2_sel     (wb_l2_sel),
        .wb_l2_dat_m   (wb_l2_dat_m),
        .wb_l2_ack     (wb_l2_ack),
        .wb_l2_rty     (wb_l2_rty),
        .wb_l2_dat_s   (wb_l2_dat_s),
        .wb_pmem_cyc   (wb_pmem_cyc),
        .wb_pmem_stb   (wb_pmem_stb),
        .wb_pmem_we    (wb_pmem_we),
        .wb_pmem_adr   (wb_pmem_adr),
        .wb_pmem_sel   (wb_pmem_sel),
        .wb_pmem_dat_m (wb_pmem_dat_m),
        .wb_pmem_ack   (wb_pmem_ack),
        .wb_pmem_rty   (wb_pmem_rty),
        .wb_pmem_dat_s (wb_pmem_dat_s),
        .full          (full),
        .empty         (empty)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc_cnt <= cyc_cnt + 1;

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic logic [LINE_W-1:0] pat(input logic [ADDR_W-1:0] a);
        return {8{4'hD, a}};
    endfunction

    function automatic logic [LINE_W-1:0] wdat(input logic [3:0] tag, input logic [ADDR_W-1:0] a);
        return {8{tag, a}};
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic exp_wr(input logic [ADDR_W-1:0] a, input logic [LINE_W-1:0] d);
        pmem_exp.push_back('{we: 1'b1, adr: a, sel: SEL_FULL_LINE, dat: d});
    endtask

    task automatic exp_rd(input logic [ADDR_W-1:0] a);
        pmem_exp.push_back('{we: 1'b0, adr: a, sel: SEL_FULL_LINE, dat: '0});
    endtask

    // pmem model: one-cycle ACK per transaction unless stalled; every transaction is scored.
    always @(negedge CLK) begin
        pmem_txn_t obs_t;
        pmem_txn_t exp_t;
        if (wb_pmem_ack) begin
            wb_pmem_ack = 1'b0;
        end else if (wb_pmem_cyc && wb_pmem_stb && !stall && !RST) begin
            wb_pmem_ack   = 1'b1;
            wb_pmem_dat_s = pat(wb_pmem_adr);
            last_pmem_ack = cyc_cnt;
            obs_t = '{we: wb_pmem_we, adr: wb_pmem_adr, sel: wb_pmem_sel, dat: wb_pmem_dat_m};
            chk("pmem_txn_expected", 256'(pmem_exp.size() != 0), 256'(1));
            if (pmem_exp.size() != 0) begin
                exp_t = pmem_exp.pop_front();
                chk("pmem_txn", 256'(obs_t), 256'(exp_t));
            end
        end
    end

    task automatic l2_write(input string tag, input logic [ADDR_W-1:0] a, input logic [LINE_W-1:0] d,
                            input int maxc, output int lat, output int ackc);
        @(negedge CLK);
        wb_l2_cyc = 1'b1; wb_l2_stb = 1'b1; wb_l2_we = 1'b1;
        wb_l2_adr = a; wb_l2_sel = SEL_FULL_LINE; wb_l2_dat_m = d;
        lat = -1; ackc = -1;
        for (int i = 0; i < maxc; i++) begin
            @(negedge CLK);
            if (wb_l2_ack) begin
                lat = i + 1; ackc = cyc_cnt;
                break;
            end
        end
        chk({tag, "_ack_seen"}, 256'(lat > 0), 256'(1));
        wb_l2_cyc = 1'b0; wb_l2_stb = 1'b0; wb_l2_we = 1'b0;
    endtask

    task automatic l2_read(input string tag, input logic [ADDR_W-1:0] a, input int maxc, output int ackc);
        logic [LINE_W-1:0] exp_d;
        @(negedge CLK);
        wb_l2_cyc = 1'b1; wb_l2_stb = 1'b1; wb_l2_we = 1'b0;
        wb_l2_adr = a; wb_l2_sel = SEL_FULL_LINE; wb_l2_dat_m = '0;
        ackc = -1;
        for (int i = 0; i < maxc; i++) begin
            @(negedge CLK);
            if (wb_l2_ack) begin
                ackc = cyc_cnt;
                break;
            end
        end
        chk({tag, "_ack_seen"}, 256'(ackc >= 0), 256'(1));
        exp_d = (rd_exp.size() != 0) ? rd_exp.pop_front() : '1;
        if (ackc >= 0) chk({tag, "_dat"}, 256'(wb_l2_dat_s), 256'(exp_d));
        wb_l2_cyc = 1'b0; wb_l2_stb = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        @(negedge CLK);
        while (!(empty && !wb_pmem_cyc) && (n < 300)) begin
            @(negedge CLK);
            n++;
        end
        chk({tag, "_drained"}, 256'(n < 300), 256'(1));
        chk({tag, "_sb_empty"}, 256'(pmem_exp.size()), 256'(0));
    endtask

    initial begin
        int lat, ackc;

        // Reset values
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        chk("rst_l2_ack", 256'(wb_l2_ack), 256'(0));
        chk("rst_l2_rty", 256'(wb_l2_rty), 256'(0));
        chk("rst_l2_dat_s", 256'(wb_l2_dat_s), 256'(0));
        chk("rst_pmem_ctl", 256'({wb_pmem_cyc, wb_pmem_stb, wb_pmem_we}), 256'(0));
        chk("rst_pmem_adr_sel", 256'({wb_pmem_adr, wb_pmem_sel}), 256'(0));
        chk("rst_pmem_dat", 256'(wb_pmem_dat_m), 256'(0));
        chk("rst_full_empty", 256'({full, empty}), 256'(2'b01));

        // 1: read miss goes to pmem, L2 ACK one cycle after pmem ACK
        exp_rd(12'h010);
        rd_exp.push_back(pat(12'h010));
        l2_read("t1_rd", 12'h010, 20, ackc);
        chk("t1_ack_latency", 256'(ackc - last_pmem_ack), 256'(1));
        wait_idle("t1");

        // 2: fill to full with pmem stalled, fifth write waits for the first drain
        stall = 1'b1;
        for (int i = 1; i <= 5; i++) exp_wr(12'(i), wdat(4'h5, 12'(i)));
        for (int i = 1; i <= 4; i++) begin
            l2_write("t2_w", 12'(i), wdat(4'h5, 12'(i)), 10, lat, ackc);
            chk("t2_w_latency", 256'(lat), 256'(1));
        end
        @(negedge CLK);
        chk("t2_full", 256'({full, empty}), 256'(2'b10));
        fork
            l2_write("t2_w5", 12'h005, wdat(4'h5, 12'h005), 60, lat, ackc);
            begin
                repeat (6) @(posedge CLK);
                #2 stall = 1'b0;
            end
        join
        chk("t2_w5_after_drain", 256'(ackc - last_pmem_ack), 256'(1));
        chk("t2_w5_stalled", 256'(lat > 3), 256'(1));
        wait_idle("t2");

        // 3: coalesce behind a stalled drain gives a single write of the newer data
        stall = 1'b1;
        exp_wr(12'h01F, wdat(4'h3, 12'h01F));
        exp_wr(12'h020, wdat(4'hB, 12'h020));
        l2_write("t3_w1f", 12'h01F, wdat(4'h3, 12'h01F), 10, lat, ackc);
        l2_write("t3_wa", 12'h020, wdat(4'hA, 12'h020), 10, lat, ackc);
        l2_write("t3_wb", 12'h020, wdat(4'hB, 12'h020), 10, lat, ackc);
        chk("t3_wb_latency", 256'(lat), 256'(1));
        @(negedge CLK);
        chk("t3_not_full", 256'({full, empty}), 256'(2'b00));
        stall = 1'b0;
        wait_idle("t3");

        // 4: read-after-write to a buffered line
        stall = 1'b1;
        exp_wr(12'h02F, wdat(4'h4, 12'h02F));
        exp_wr(12'h030, wdat(4'hC, 12'h030));
`ifdef L2WB_RAW_FWD_EN
        rd_exp.push_back(wdat(4'hC, 12'h030));
`else
        exp_rd(12'h030);
        rd_exp.push_back(pat(12'h030));
`endif
        l2_write("t4_w2f", 12'h02F, wdat(4'h4, 12'h02F), 10, lat, ackc);
        l2_write("t4_w30", 12'h030, wdat(4'hC, 12'h030), 10, lat, ackc);
        fork
            l2_read("t4_rd", 12'h030, 60, ackc);
            begin
                repeat (4) @(posedge CLK);
                #2 stall = 1'b0;
            end
        join
        wait_idle("t4");

        // 5: write accepted on the very cycle a drain is ACKed
        stall = 1'b1;
        exp_wr(12'h040, wdat(4'h6, 12'h040));
        exp_wr(12'h041, wdat(4'h7, 12'h041));
        l2_write("t5_w40", 12'h040, wdat(4'h6, 12'h040), 10, lat, ackc);
        repeat (3) @(negedge CLK);
        chk("t5_drain_stalled", 256'(wb_pmem_cyc), 256'(1));
        @(posedge CLK);
        #2 stall = 1'b0;
        l2_write("t5_w41", 12'h041, wdat(4'h7, 12'h041), 10, lat, ackc);
        chk("t5_same_cycle", 256'(ackc - last_pmem_ack), 256'(1));
        chk("t5_latency", 256'(lat), 256'(1));
        chk("t5_count_kept", 256'({full, empty}), 256'(2'b00));
        wait_idle("t5");

        // 6: reset in the middle of a drain
        stall = 1'b1;
        l2_write("t6_w50", 12'h050, wdat(4'h8, 12'h050), 10, lat, ackc);
        repeat (2) @(negedge CLK);
        chk("t6_in_drain", 256'(wb_pmem_cyc), 256'(1));
        RST = 1'b1;
        @(negedge CLK);
        chk("t6_rst_cyc_stb", 256'({wb_pmem_cyc, wb_pmem_stb}), 256'(0));
        chk("t6_rst_empty", 256'({full, empty}), 256'(2'b01));
        RST = 1'b0;
        stall = 1'b0;
        exp_rd(12'h050);
        rd_exp.push_back(pat(12'h050));
        l2_read("t6_rd", 12'h050, 20, ackc);
        wait_idle("t6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
